// File: rtl/dmem_responder.sv
// Single-ported data memory responder for an RV32I load/store unit.
// Three-phase handshake (IDLE -> ACCESS -> RESP) over byte-lane RAMs with a registered read.
module dmem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h0001_0000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic        err_q;

  logic [31:0] offset;
  logic        in_range;
  logic        bad_type;
  logic        access_err;
  logic [IDX_W-1:0] word_idx;
  logic [3:0]  byte_en;
  logic [31:0] wdata_lanes;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] rd_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ACCESS;
      end
      ACCESS: state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request fields are only sampled on the IDLE handshake, so req_* are ignored elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      err_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        we_q     <= req_we;
        funct3_q <= req_funct3;
      end
      if (state_q == ACCESS) begin
        err_q <= access_err;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Address decode and access legality
  // ---------------------------------------------------------------------------
  always_comb begin
    offset   = addr_q - ADDR_BASE;
    in_range = (addr_q >= ADDR_BASE) && ({1'b0, offset} < SPAN_BYTES);
    word_idx = offset[IDX_W+1:2];
    case (funct3_q)
      3'b000:  bad_type = 1'b0;
      3'b001:  bad_type = addr_q[0];
      3'b010:  bad_type = |addr_q[1:0];
      3'b100:  bad_type = we_q;
      3'b101:  bad_type = we_q | addr_q[0];
      default: bad_type = 1'b1;
    endcase
    access_err = !in_range || bad_type;
  end

  // Store data is replicated across lanes so each lane RAM only needs its enable.
  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        byte_en     = 4'b0001 << addr_q[1:0];
        wdata_lanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        byte_en     = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        byte_en     = 4'b1111;
        wdata_lanes = wdata_q;
      end
      default: begin
        byte_en     = 4'b0000;
        wdata_lanes = wdata_q;
      end
    endcase
  end

  // rst gates the write so a store caught by reset mid-ACCESS never lands.
  assign wr_en = (state_q == ACCESS) && we_q && !access_err && !rst;
  assign rd_en = (state_q == ACCESS) && !we_q;

  // ---------------------------------------------------------------------------
  // Byte-lane storage, no reset on contents
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_lane [DEPTH_WORDS];
      logic [7:0] rd_lane_q;

      always_ff @(posedge clk) begin
        if (wr_en && byte_en[gi]) begin
          mem_lane[word_idx] <= wdata_lanes[gi*8 +: 8];
        end
        if (rd_en) begin
          rd_lane_q <= mem_lane[word_idx];
        end
      end

      assign rd_word[gi*8 +: 8] = rd_lane_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Load alignment and extension
  // ---------------------------------------------------------------------------
  always_comb begin
    byte_sel = rd_word[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (funct3_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'h0, byte_sel};
      3'b101:  load_val = {16'h0, half_sel};
      default: load_val = rd_word;
    endcase
  end

  // Data is zero outside a successful load response, which also covers reset.
  assign rsp_rdata = (state_q == RESP && !we_q && !err_q) ? load_val : 32'h0;
  assign rsp_err   = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed bench for dmem_responder against a byte-addressed memory model.
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] ref_mem [4*DEPTH];

  dmem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: a flat byte array, little-endian
  // ---------------------------------------------------------------------------
  function automatic int access_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit ref_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int     size;
    longint off;
    size = access_size(f3);
    if (size == 0) return 1'b1;
    if (we && f3[2]) return 1'b1;
    off = longint'(addr) - longint'(BASE);
    if (off < 0 || off >= 4 * DEPTH) return 1'b1;
    if ((addr % size) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    int          size;
    int          off;
    logic [31:0] v;
    size = access_size(f3);
    off  = int'(addr - BASE);
    v    = 32'h0;
    for (int i = 0; i < size; i++) v = v | (32'(ref_mem[off + i]) << (8 * i));
    if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    int size;
    int off;
    size = access_size(f3);
    off  = int'(addr - BASE);
    for (int i = 0; i < size; i++) ref_mem[off + i] = wdata[8*i +: 8];
  endtask

  // ---------------------------------------------------------------------------
  // One full request/response exchange with latency and stability checks
  // ---------------------------------------------------------------------------
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input int hold,
                     output logic [31:0] rdata, output logic err);
    int waited;
    waited = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL req_ready_wait addr=%h actual=%b required=1", addr, req_ready);
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    // Leave a live store request on the bus while busy; it must be ignored.
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = BASE + 32'(4 * $urandom_range(0, 15));
    req_wdata  = $urandom;
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL latency_access addr=%h rsp_valid=%b req_ready=%b required 0/0", addr, rsp_valid, req_ready);
    end
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL latency_resp addr=%h rsp_valid=%b required=1", addr, rsp_valid);
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      tests_run++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== rdata || rsp_err !== err) begin
        tests_failed++;
        $display("FAIL hold_stable cycle=%0d valid=%b ready=%b rdata=%h err=%b required 1/0/%h/%b",
                 h, rsp_valid, req_ready, rsp_rdata, rsp_err, rdata, err);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL release addr=%h rsp_valid=%b req_ready=%b required 0/1", addr, rsp_valid, req_ready);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    rsp_ready  = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs valid=%b err=%b rdata=%h required 0/0/0", rsp_valid, rsp_err, rsp_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release req_ready=%b rsp_valid=%b required 1/0", req_ready, rsp_valid);
    end
    $display("[TB] reset done");
  endtask

  task automatic run_table(input string name, input int n,
                           input logic we_t [8], input logic [2:0] f3_t [8],
                           input logic [31:0] addr_t [8], input logic [31:0] wd_t [8],
                           input logic [31:0] exp_t [8], input logic experr_t [8]);
    logic [31:0] rd;
    logic        er;
    for (int i = 0; i < n; i++) begin
      txn(we_t[i], f3_t[i], addr_t[i], wd_t[i], 0, rd, er);
      if (!experr_t[i] && we_t[i]) ref_store(f3_t[i], addr_t[i], wd_t[i]);
      $display("[TB] %s #%0d we=%b f3=%0d addr=%h -> rdata=%h err=%b", name, i, we_t[i], f3_t[i], addr_t[i], rd, er);
      tests_run++;
      if (rd !== exp_t[i] || er !== experr_t[i]) begin
        tests_failed++;
        $display("FAIL %s_%0d rdata=%h err=%b required %h/%b", name, i, rd, er, exp_t[i], experr_t[i]);
      end
    end
  endtask

  task automatic test_directed();
    logic        we_t [8]     = '{1, 0, 0, 0, 0, 0, 1, 0};
    logic [2:0]  f3_t [8]     = '{3'b010, 3'b010, 3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010};
    logic [31:0] addr_t [8]   = '{32'h0001_0004, 32'h0001_0004, 32'h0001_0007, 32'h0001_0007,
                                  32'h0001_0004, 32'h0001_0006, 32'h0001_0005, 32'h0001_0004};
    logic [31:0] wd_t [8]     = '{32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0012, 32'h0};
    logic [31:0] exp_t [8]    = '{32'h0, 32'hDEAD_BEEF, 32'hFFFF_FFDE, 32'h0000_00DE,
                                  32'hFFFF_BEEF, 32'h0000_DEAD, 32'h0, 32'hDEAD_12EF};
    logic        experr_t [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_table("directed", 8, we_t, f3_t, addr_t, wd_t, exp_t, experr_t);
  endtask

  task automatic test_errors();
    logic        we_t [8]     = '{0, 1, 0, 0, 0, 0, 0, 0};
    logic [2:0]  f3_t [8]     = '{3'b010, 3'b001, 3'b010, 3'b010, 3'b011, 3'b010, 3'b010, 3'b010};
    logic [31:0] addr_t [8]   = '{32'h0001_0002, 32'h0001_0001, 32'h0000_FFFC, 32'h0001_1000,
                                  32'h0001_0004, 32'h0001_0004, 32'h0001_0000, 32'h0001_0000};
    logic [31:0] wd_t [8]     = '{32'h0, 32'h0000_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] exp_t [8]    = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hDEAD_12EF, 32'h0, 32'h0};
    logic        experr_t [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
    run_table("errors", 6, we_t, f3_t, addr_t, wd_t, exp_t, experr_t);
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    logic        er;
    txn(1'b0, 3'b010, 32'h0001_0004, 32'h0, 5, rd, er);
    $display("[TB] backpressure lw addr=00010004 hold=5 -> rdata=%h err=%b", rd, er);
    tests_run++;
    if (rd !== 32'hDEAD_12EF || er !== 1'b0) begin
      tests_failed++;
      $display("FAIL backpressure_data rdata=%h err=%b required DEAD12EF/0", rd, er);
    end
  endtask

  task automatic test_reset_access();
    logic [31:0] rd;
    logic        er;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h0001_0004;
    req_wdata  = 32'h0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst       = 1'b1;
    #1;
    tests_run++;
    if (rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_access_immediate rsp_valid=%b required=0", rsp_valid);
    end
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_access_held valid=%b err=%b rdata=%h required 0/0/0", rsp_valid, rsp_err, rsp_rdata);
    end
    rst = 1'b0;
    txn(1'b0, 3'b010, 32'h0001_0004, 32'h0, 0, rd, er);
    $display("[TB] reset_access lw addr=00010004 -> rdata=%h err=%b", rd, er);
    tests_run++;
    if (rd !== 32'hDEAD_12EF || er !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_access_store_suppressed rdata=%h err=%b required DEAD12EF/0", rd, er);
    end
  endtask

  task automatic test_reset_resp();
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b011;
    req_addr   = 32'h0001_0004;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_resp_drop valid=%b err=%b rdata=%h required 0/0/0", rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_resp_idle req_ready=%b rsp_valid=%b required 1/0", req_ready, rsp_valid);
    end
    $display("[TB] reset during RESP dropped response");
  endtask

  function automatic logic [31:0] pick_word_addr(input int w);
    // Words 0..15 at the bottom and 1020..1023 at the top of the window.
    if (w < 16) return BASE + 32'(4 * w);
    return BASE + 32'(4 * (1004 + w));
  endfunction

  task automatic test_random();
    logic [31:0] rd, addr, wd, exp_rd;
    logic        er, we, exp_er;
    logic [2:0]  f3;
    int          sel;
    for (int w = 0; w < 20; w++) begin
      addr = pick_word_addr(w);
      wd   = $urandom;
      txn(1'b1, 3'b010, addr, wd, 0, rd, er);
      ref_store(3'b010, addr, wd);
      $display("[TB] preload sw addr=%h wdata=%h -> err=%b", addr, wd, er);
      tests_run++;
      if (er !== 1'b0 || rd !== 32'h0) begin
        tests_failed++;
        $display("FAIL preload_%0d rdata=%h err=%b required 0/0", w, rd, er);
      end
    end
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)
        addr = ($urandom_range(0, 1) == 0) ? BASE - 32'($urandom_range(1, 8))
                                           : BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
      else
        addr = pick_word_addr($urandom_range(0, 19)) + 32'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      wd = $urandom;
      exp_er = ref_err(we, f3, addr);
      exp_rd = (exp_er || we) ? 32'h0 : ref_load(f3, addr);
      txn(we, f3, addr, wd, $urandom_range(0, 2), rd, er);
      if (!exp_er && we) ref_store(f3, addr, wd);
      $display("[TB] rand #%0d we=%b f3=%0d addr=%h wdata=%h -> rdata=%h err=%b", n, we, f3, addr, wd, rd, er);
      tests_run++;
      if (rd !== exp_rd || er !== exp_er) begin
        tests_failed++;
        $display("FAIL random_%0d rdata=%h err=%b required %h/%b", n, rd, er, exp_rd, exp_er);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_backpressure();
    test_reset_access();
    test_reset_resp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

endmodule
